// File: rtl/cpu_regfile.sv
// SM83 architectural register file: B..L, A, F, SP, PC with combinational
// read ports, prioritised writes and PC/SP/HL increment/decrement.
module cpu_regfile #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rdSelA,
    output logic [7:0]  rdDataA,
    input  logic [2:0]  rdSelB,
    output logic [7:0]  rdDataB,
    input  logic [2:0]  rdSel16,
    output logic [15:0] rdData16,
    input  logic        we8,
    input  logic [2:0]  wrSel8,
    input  logic [7:0]  wrData8,
    input  logic        we16,
    input  logic [2:0]  wrSel16,
    input  logic [15:0] wrData16,
    input  logic        flagWe,
    input  logic [3:0]  flagMask,
    input  logic [3:0]  flagIn,
    input  logic        pcInc,
    input  logic        spInc,
    input  logic        spDec,
    input  logic        hlInc,
    input  logic        hlDec,
    output logic [3:0]  flags,
    output logic [15:0] pc,
    output logic [15:0] sp,
    output logic [15:0] hl
);

    typedef enum logic [2:0] {
        R_B = 3'd0, R_C = 3'd1, R_D = 3'd2, R_E = 3'd3,
        R_H = 3'd4, R_L = 3'd5, R_F = 3'd6, R_A = 3'd7
    } reg8_e;

    typedef enum logic [2:0] {
        P_BC = 3'd0, P_DE = 3'd1, P_HL = 3'd2,
        P_SP = 3'd3, P_AF = 3'd4, P_PC = 3'd5
    } pair_e;

    logic [7:0]  b_q, c_q, d_q, e_q, h_q, l_q, a_q;
    logic [7:0]  b_d, c_d, d_d, e_d, h_d, l_d, a_d;
    // Only the flag nibble F[7:4] is stored; F[3:0] is hardwired to zero.
    logic [3:0]  f_q, f_d;
    logic [15:0] sp_q, sp_d, pc_q, pc_d;
    logic        hl_touched;

    logic unused_low_nibbles;
    assign unused_low_nibbles = ^{wrData8[3:0], wrData16[3:0]};

    function automatic logic [7:0] read8(input logic [2:0] sel);
        logic [7:0] v;
        v = '0;
        case (sel)
            R_B: v = b_q;
            R_C: v = c_q;
            R_D: v = d_q;
            R_E: v = e_q;
            R_H: v = h_q;
            R_L: v = l_q;
            R_F: v = {f_q, 4'h0};
            R_A: v = a_q;
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        rdDataA = read8(rdSelA);
        rdDataB = read8(rdSelB);
        rdData16 = '0;
        case (rdSel16)
            P_BC:    rdData16 = {b_q, c_q};
            P_DE:    rdData16 = {d_q, e_q};
            P_HL:    rdData16 = {h_q, l_q};
            P_SP:    rdData16 = sp_q;
            P_AF:    rdData16 = {a_q, f_q, 4'h0};
            P_PC:    rdData16 = pc_q;
            default: rdData16 = '0;
        endcase
    end

    assign flags = f_q;
    assign pc    = pc_q;
    assign sp    = sp_q;
    assign hl    = {h_q, l_q};

    assign hl_touched = (we8  && (wrSel8 == R_H || wrSel8 == R_L)) ||
                        (we16 && wrSel16 == P_HL);

    // Lowest priority first: later assignments (we8, then we16) override.
    always_comb begin
        b_d  = b_q;
        c_d  = c_q;
        d_d  = d_q;
        e_d  = e_q;
        h_d  = h_q;
        l_d  = l_q;
        a_d  = a_q;
        f_d  = f_q;
        sp_d = sp_q;
        pc_d = pc_q;

        if (flagWe)
            f_d = (f_q & ~flagMask) | (flagIn & flagMask);
        if (pcInc)
            pc_d = pc_q + 16'd1;
        if (spInc && !spDec)
            sp_d = sp_q + 16'd1;
        else if (spDec && !spInc)
            sp_d = sp_q - 16'd1;
        if (!hl_touched) begin
            if (hlInc && !hlDec)
                {h_d, l_d} = {h_q, l_q} + 16'd1;
            else if (hlDec && !hlInc)
                {h_d, l_d} = {h_q, l_q} - 16'd1;
        end

        if (we8) begin
            case (wrSel8)
                R_B:     b_d = wrData8;
                R_C:     c_d = wrData8;
                R_D:     d_d = wrData8;
                R_E:     e_d = wrData8;
                R_H:     h_d = wrData8;
                R_L:     l_d = wrData8;
                R_F:     f_d = wrData8[7:4];
                R_A:     a_d = wrData8;
                default: ;
            endcase
        end

        if (we16) begin
            case (wrSel16)
                P_BC:    {b_d, c_d} = wrData16;
                P_DE:    {d_d, e_d} = wrData16;
                P_HL:    {h_d, l_d} = wrData16;
                P_SP:    sp_d = wrData16;
                P_AF: begin
                    a_d = wrData16[15:8];
                    f_d = wrData16[7:4];
                end
                P_PC:    pc_d = wrData16;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q  <= '0;
            c_q  <= '0;
            d_q  <= '0;
            e_q  <= '0;
            h_q  <= '0;
            l_q  <= '0;
            a_q  <= '0;
            f_q  <= '0;
            sp_q <= SP_RESET;
            pc_q <= PC_RESET;
        end else begin
            b_q  <= b_d;
            c_q  <= c_d;
            d_q  <= d_d;
            e_q  <= e_d;
            h_q  <= h_d;
            l_q  <= l_d;
            a_q  <= a_d;
            f_q  <= f_d;
            sp_q <= sp_d;
            pc_q <= pc_d;
        end
    end

endmodule
